// File: rtl/fifo_reader_pkg.sv
// Shared definitions for the FIFO-to-serial reader: state type, default word
// width and the bit-index width helper.
package fifo_reader_pkg;

    localparam int unsigned DEFAULT_WIDTH = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    function automatic int unsigned idx_width(input int unsigned w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/fifo_reader_if.sv
// Upstream FIFO pop port and downstream serial port of the reader.
interface fifo_reader_if
    import fifo_reader_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
);
    logic             fifo_busy;
    logic [WIDTH-1:0] fifo_rd_data;
    logic             fifo_rd_e;
    logic             ser_valid;
    logic             ser_data;
    logic             ser_last;
    logic             ser_ready;

    modport master (
        input  fifo_busy, fifo_rd_data, ser_ready,
        output fifo_rd_e, ser_valid, ser_data, ser_last
    );

    modport slave (
        output fifo_busy, fifo_rd_data, ser_ready,
        input  fifo_rd_e, ser_valid, ser_data, ser_last
    );
endinterface

// File: rtl/fifo_reader_piso_shift.sv
// Parallel-in serial-out shift register with bit index; load wins over shift.
module fifo_reader_piso_shift
    import fifo_reader_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             bit0,
    output logic             last
);
    localparam int unsigned IDX_W = idx_width(WIDTH);

    logic [WIDTH-1:0] sreg;
    logic [IDX_W-1:0] idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            sreg <= '0;
            idx  <= '0;
        end else if (load) begin
            sreg <= din;
            idx  <= '0;
        end else if (shift) begin
            sreg <= sreg >> 1;
            idx  <= idx + IDX_W'(1);
        end
    end

    assign bit0 = sreg[0];
    assign last = (idx == IDX_W'(WIDTH - 1));

endmodule

// File: rtl/fifo_reader.sv
// Pops words from an upstream FIFO and streams them LSB first, refetching on
// the last bit so back-to-back words leave no gap on ser_valid.
module fifo_reader
    import fifo_reader_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    fifo_reader_if.master    bus,
    output logic [CNT_W-1:0] word_count,
    output logic             idle
);
    state_t state, state_nxt;
    logic   fetch_ok;
    logic   xfer;
    logic   load;
    logic   shift;
    logic   count_inc;
    logic   bit0;
    logic   last;

    assign fetch_ok = enable && bus.fifo_busy && !rst;
    assign xfer     = (state == SHIFT) && bus.ser_ready && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        bus.fifo_rd_e = 1'b0;
        load          = 1'b0;
        shift         = 1'b0;
        count_inc     = 1'b0;
        case (state)
            IDLE: begin
                if (fetch_ok) begin
                    bus.fifo_rd_e = 1'b1;
                    load          = 1'b1;
                    state_nxt     = SHIFT;
                end
            end
            SHIFT: begin
                if (xfer) begin
                    if (last) begin
                        count_inc = 1'b1;
                        // Refetch in the same cycle keeps ser_valid continuous
                        if (fetch_ok) begin
                            bus.fifo_rd_e = 1'b1;
                            load          = 1'b1;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end else begin
                        shift = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            word_count <= '0;
        end else if (count_inc) begin
            word_count <= word_count + CNT_W'(1);
        end
    end

    fifo_reader_piso_shift #(.WIDTH(WIDTH)) u_piso (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .shift (shift),
        .din   (bus.fifo_rd_data),
        .bit0  (bit0),
        .last  (last)
    );

    // Outputs are forced quiet during reset even if state has not yet cleared
    assign bus.ser_valid = (state == SHIFT) && !rst;
    assign bus.ser_data  = bus.ser_valid && bit0;
    assign bus.ser_last  = bus.ser_valid && last;
    assign idle          = (state == IDLE) || rst;

endmodule

// File: tb/tb_fifo_reader.sv
// Directed and random stimulus for fifo_reader checked against a bit-queue
// reference model; a second instance with CNT_W=2 checks counter wrap.
module tb_fifo_reader;
    import fifo_reader_pkg::*;

    logic       clk;
    logic       rst;
    logic       enable;
    logic [7:0] word_count;
    logic [1:0] word_count2;
    logic       idle;
    logic       idle2;

    fifo_reader_if #(.WIDTH(2)) bus1 ();
    fifo_reader_if #(.WIDTH(2)) bus2 ();

    assign bus2.fifo_busy    = bus1.fifo_busy;
    assign bus2.fifo_rd_data = bus1.fifo_rd_data;
    assign bus2.ser_ready    = bus1.ser_ready;

    fifo_reader #(.WIDTH(2), .CNT_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .bus        (bus1),
        .word_count (word_count),
        .idle       (idle)
    );

    fifo_reader #(.WIDTH(2), .CNT_W(2)) dut2 (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .bus        (bus2),
        .word_count (word_count2),
        .idle       (idle2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    bit          bits_q[$];
    logic [1:0]  src_q[$];
    int unsigned m_count = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        logic       exp_valid, exp_data, exp_last, exp_rd, exp_idle;
        logic [1:0] w;
        bus1.fifo_busy    = (src_q.size() > 0);
        bus1.fifo_rd_data = (src_q.size() > 0) ? src_q[0] : 2'b00;
        @(negedge clk);
        exp_valid = !rst && (bits_q.size() > 0);
        exp_data  = exp_valid ? bits_q[0] : 1'b0;
        exp_last  = exp_valid && (bits_q.size() == 1);
        exp_rd    = !rst && enable && bus1.fifo_busy &&
                    ((bits_q.size() == 0) || ((bits_q.size() == 1) && bus1.ser_ready));
        exp_idle  = rst || (bits_q.size() == 0);
        chk("fifo_rd_e",   32'(bus1.fifo_rd_e), 32'(exp_rd));
        chk("ser_valid",   32'(bus1.ser_valid), 32'(exp_valid));
        chk("ser_data",    32'(bus1.ser_data),  32'(exp_data));
        chk("ser_last",    32'(bus1.ser_last),  32'(exp_last));
        chk("idle",        32'(idle),           32'(exp_idle));
        chk("word_count",  32'(word_count),     m_count % 256);
        chk("rd_e_w2",     32'(bus2.fifo_rd_e), 32'(exp_rd));
        chk("ser_valid_w2", 32'(bus2.ser_valid), 32'(exp_valid));
        chk("word_count_w2", 32'(word_count2),  m_count % 4);
        if (rst) begin
            bits_q.delete();
            m_count = 0;
        end else begin
            if (exp_valid && bus1.ser_ready) begin
                void'(bits_q.pop_front());
                if (bits_q.size() == 0) m_count++;
            end
            if (exp_rd) begin
                w = src_q.pop_front();
                for (int i = 0; i < 2; i++) bits_q.push_back(w[i]);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst            = 1'b1;
        enable         = 1'b1;
        bus1.ser_ready = 1'b1;
        src_q.push_back(2'b10);

        // Reset held with a word waiting
        repeat (3) tick();
        rst = 1'b0;
        repeat (4) tick();

        // Downstream stall on word 01
        src_q.push_back(2'b01);
        bus1.ser_ready = 1'b0;
        repeat (4) tick();
        bus1.ser_ready = 1'b1;
        repeat (3) tick();

        // Back-to-back words
        src_q.push_back(2'b01);
        src_q.push_back(2'b11);
        repeat (6) tick();

        // Reset after the first bit of a word
        src_q.push_back(2'b10);
        repeat (2) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();

        // Enable dropped mid-word: word completes, next one waits
        src_q.push_back(2'b11);
        src_q.push_back(2'b01);
        repeat (2) tick();
        enable = 1'b0;
        repeat (4) tick();
        enable = 1'b1;
        repeat (4) tick();

        // Enough extra words to wrap the 2-bit counter
        for (int k = 0; k < 5; k++) src_q.push_back(2'(k));
        repeat (14) tick();

        for (int n = 0; n < 400; n++) begin
            enable         = ($urandom_range(0, 9) != 0);
            bus1.ser_ready = ($urandom_range(0, 3) != 0);
            rst            = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 2) == 0 && src_q.size() < 4)
                src_q.push_back(2'($urandom));
            tick();
        end

        rst            = 1'b0;
        enable         = 1'b1;
        bus1.ser_ready = 1'b1;
        repeat (20) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
